// File: rtl/alu_seq_core.sv
// Sequential ALU core: IDLE/CALC/DONE handshake with per-result error, sticky error flag and saturating error counter.
// Optional build macro ALU_SATURATE_EN: clamp ADD overflow to all ones and SUB underflow to zero instead of wrapping.
module alu_seq_core #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ack,
    input  logic             clear_err,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             error,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

`ifdef ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       r_op_p0;
    logic [WIDTH-1:0] r_a_p0;
    logic [WIDTH-1:0] r_b_p0;

    logic [WIDTH-1:0] r_f_p1;
    logic             r_err_p1;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_err;

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] val,
                                                 input logic             ovf);
        return (SAT && ovf) ? {WIDTH{1'b1}} : val;
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] val,
                                                 input logic             unf);
        return (SAT && unf) ? {WIDTH{1'b0}} : val;
    endfunction

    // A DONE result is retired by ack; pairing it with start chains the next operation.
    assign w_accept = start && ((r_state == S_IDLE) || ((r_state == S_DONE) && ack));

    // ---- stage p0: operands captured on acceptance ----
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_p0 <= op;
            r_a_p0  <= a;
            r_b_p0  <= b;
        end
    end

    always_comb begin
        w_sum  = {1'b0, r_a_p0} + {1'b0, r_b_p0};
        w_diff = {1'b0, r_a_p0} - {1'b0, r_b_p0};
        w_res  = '0;
        w_err  = 1'b0;
        case (r_op_p0)
            2'b00: w_res = ~r_a_p0;
            2'b01: w_res = r_a_p0 & r_b_p0;
            2'b10: begin
                w_res = sat_add(w_sum[WIDTH-1:0], w_sum[WIDTH]);
                w_err = w_sum[WIDTH];
            end
            default: begin
                // The borrow bit of the extended difference is exactly a < b.
                w_res = sat_sub(w_diff[WIDTH-1:0], w_diff[WIDTH]);
                w_err = w_diff[WIDTH];
            end
        endcase
    end

    // ---- stage p1: control FSM, registered result and error bookkeeping ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_f_p1   <= '0;
            r_err_p1 <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (clear_err) begin
                r_sticky <= 1'b0;
                r_cnt    <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_f_p1   <= w_res;
                    r_err_p1 <= w_err;
                    r_state  <= S_DONE;
                    r_done   <= 1'b1;
                    // An error landing with clear_err wins over the clear.
                    if (w_err) begin
                        r_sticky <= 1'b1;
                        if (clear_err) begin
                            r_cnt <= CNT_W'(1);
                        end else if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        r_done <= 1'b0;
                        if (start) begin
                            r_state <= S_CALC;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign f          = r_f_p1;
    assign error      = r_err_p1;
    assign err_sticky = r_sticky;
    assign err_cnt    = r_cnt;

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter WIDTH, default 2, operand and result width in bits (legal 2..32).
REQ-002 Parameter CNT_W, default 4, error-counter width in bits (legal 1..16).
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request a new operation; sampled only when accepted per REQ-012.
REQ-006 op  input  2  opcode: 00 NOT a, 01 a AND b, 10 a+b, 11 a-b.
REQ-007 a, b  input  WIDTH each  operands, unsigned.
REQ-008 ack  input  1  consumer accepts the presented result.
REQ-009 clear_err  input  1  clears err_sticky and err_cnt.
REQ-010 busy  output  1; done  output  1; f  output  WIDTH result; error  output  1 per-result error; err_sticky  output  1; err_cnt  output  CNT_W.

Function
REQ-011 FSM states IDLE, CALC and DONE; busy=1 in CALC and DONE; done=1 only in DONE.
REQ-012 Start accepted in IDLE, or in DONE when ack=1 the same cycle; otherwise start is ignored and has no effect.
REQ-013 On acceptance, op, a and b are latched and the FSM enters CALC next cycle; later input changes do not affect that operation.
REQ-014 CALC lasts exactly one cycle, computes from latched operands, registers f and error, then enters DONE.
REQ-015 Latency: start accepted at edge t -> done=1 from edge t+2 onward.
REQ-016 DONE holds f, error and done stable until ack=1; ack with no accepted start -> IDLE; ack with start -> CALC (back-to-back, one idle-free cycle).
REQ-017 ack outside DONE is ignored.
REQ-018 NOT: f = bitwise inverse of a, error=0; AND: f = a & b, error=0.
REQ-019 ADD: computed at WIDTH+1 bits; error=1 iff carry-out; f = low WIDTH bits (subject to REQ-027).
REQ-020 SUB: error=1 iff a < b (underflow); f = (a-b) mod 2^WIDTH (subject to REQ-027).
REQ-021 err_sticky sets on the CALC->DONE transition carrying error=1 and stays set until clear_err or reset.
REQ-022 err_cnt increments by one on each such transition, saturating at all ones (no wrap).
REQ-023 clear_err sets err_sticky=0, err_cnt=0; if an error result is registered the same cycle, err_sticky=1 and err_cnt=1 result.
REQ-024 f and error retain their last values in IDLE.

Reset
REQ-025 rst asserted at any time, including mid-CALC or in DONE, forces IDLE immediately; in-flight operation discarded.
REQ-026 Reset values: busy=0, done=0, f=0, error=0, err_sticky=0, err_cnt=0; first accepted start possible on first edge after rst deasserts.

Configuration
REQ-027 Macro ALU_SATURATE_EN: when defined, ADD overflow yields f = all ones and SUB underflow yields f = 0, error still asserted; when undefined, results wrap modulo 2^WIDTH per REQ-019/REQ-020.
REQ-028 NOT/AND behaviour and all error/counter behaviour are identical with or without ALU_SATURATE_EN.

Verification (WIDTH=2, CNT_W=4 unless stated)
REQ-029 rst pulse, op=10 a=01 b=01 start at t -> done=1 at t+2, f=10, error=0, busy=1 at t+1 and t+2.
REQ-030 op=10 a=11 b=10 -> error=1, f=01 without macro, f=11 with ALU_SATURATE_EN; err_sticky=1, err_cnt=1.
REQ-031 op=11 a=01 b=10 -> error=1, f=11 without macro, f=00 with macro; op=00 a=10 -> f=01 error=0; op=01 a=11 b=10 -> f=10.
REQ-032 DONE held 5 cycles without ack -> f/done stable; ack+start(op=01 a=11 b=01) same cycle -> next done 2 cycles later, f=01; start during CALC ignored.
REQ-033 17 overflowing ADDs -> err_cnt saturates at 1111; clear_err concurrent with an error result -> err_cnt=0001, err_sticky=1.
REQ-034 rst asserted during CALC -> busy=0, done=0, f=0 immediately; WIDTH=8: a=200 b=100 ADD -> error=1, f=44 (wrap) or 255 (saturate).
